// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM link: command opcodes, master FSM
// state encoding and the host command word layout.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_TURN     = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_DESELECT = 3'd5;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] payload;
    } spi_cmd_t;

    // Terminal SHIFT count: read-data sends only the opcode, the rest send all 10 bits.
    function automatic logic [3:0] shift_last(input logic [1:0] op);
        return (op == CMD_RD_DATA) ? 4'd1 : 4'd9;
    endfunction

endpackage

// File: rtl/spi_master_interface_if.sv
// Host-side command/response bus of the SPI master.
interface spi_master_interface_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;

    // master: the host issuing commands; slave: the SPI controller serving them
    modport master (output cmd_valid, output cmd_data,
                    input  cmd_ready, input  rd_valid, input rd_data);
    modport slave  (input  cmd_valid, input  cmd_data,
                    output cmd_ready, output rd_valid, output rd_data);
endinterface

// File: rtl/spi_master_interface.sv
// SPI master: serialises 10-bit host commands MSB-first under SS_n and
// captures the 8-bit MISO reply of read-data commands.
module spi_master_interface
    import spi_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned GAP        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_master_interface_if.slave  host,
    output logic                   SS_n,
    output logic                   MOSI,
    input  logic                   MISO
);

    localparam logic [3:0] SELECT_LAST = 4'd1;
    localparam logic [3:0] TURN_LAST   = 4'(TURNAROUND - 1);
    localparam logic [3:0] READ_LAST   = 4'd7;
    localparam logic [3:0] GAP_LAST    = 4'(GAP - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic [3:0] last_q;
    logic       rd_op_q;
    logic [9:0] sr;
    logic       cmd_ready_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;
    spi_cmd_t   cmd_in;

    assign cmd_in         = host.cmd_data;
    assign host.cmd_ready = cmd_ready_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            last_q      <= 4'd0;
            rd_op_q     <= 1'b0;
            sr          <= 10'd0;
            SS_n        <= 1'b1;
            MOSI        <= 1'b0;
            cmd_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SS_n        <= 1'b1;
                    MOSI        <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    if (host.cmd_valid && cmd_ready_q) begin
                        sr          <= cmd_in;
                        last_q      <= shift_last(cmd_in.op);
                        rd_op_q     <= (cmd_in.op == CMD_RD_DATA);
                        cmd_ready_q <= 1'b0;
                        SS_n        <= 1'b0;
                        MOSI        <= cmd_in.op[1];
                        cnt         <= 4'd0;
                        state       <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    // MOSI already holds cmd[9]; the first SHIFT cycle presents it again
                    if (cnt == SELECT_LAST) begin
                        cnt   <= 4'd0;
                        MOSI  <= sr[9];
                        sr    <= {sr[8:0], 1'b0};
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == last_q) begin
                        cnt  <= 4'd0;
                        MOSI <= 1'b0;
                        if (rd_op_q) begin
                            state <= ST_TURN;
                        end else begin
                            SS_n  <= 1'b1;
                            state <= ST_DESELECT;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        MOSI <= sr[9];
                        sr   <= {sr[8:0], 1'b0};
                    end
                end
                ST_TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt   <= 4'd0;
                        state <= ST_READ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_READ: begin
                    // The command register is free now and doubles as the MISO shifter
                    sr <= {sr[8:0], MISO};
                    if (cnt == READ_LAST) begin
                        cnt        <= 4'd0;
                        rd_data_q  <= {sr[6:0], MISO};
                        rd_valid_q <= 1'b1;
                        SS_n       <= 1'b1;
                        state      <= ST_DESELECT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DESELECT: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        cnt         <= 4'd0;
                        cmd_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    cnt         <= 4'd0;
                    SS_n        <= 1'b1;
                    MOSI        <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    a_rdv_deselected: assert property (@(posedge clk) disable iff (rst)
        rd_valid_q |-> SS_n);
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt <= 4'd14);

endmodule

// File: tb/tb_spi_master_interface.sv
// Directed bench for spi_master_interface: table of whole frames plus
// hand-written back-to-back, mid-frame toggle and mid-read reset sequences.
module tb_spi_master_interface;

    localparam int T   = 2;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst;
    logic SS_n, MOSI, MISO;
    logic [7:0] miso_byte;
    int checks = 0;
    int errors = 0;
    int midx = 0;

    spi_master_interface_if hif();

    spi_master_interface #(.TURNAROUND(T), .GAP(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (hif),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    // Slave model: reply bits sit in the 8 cycles after 2 select, 2 opcode and T turnaround cycles
    always @(negedge clk) begin
        if (SS_n) begin
            midx = 0;
            MISO = 1'b1;
        end else begin
            if (midx >= 4 + T && midx < 12 + T) MISO = miso_byte[11 + T - midx];
            else MISO = 1'b1;
            midx++;
        end
    end

    typedef struct {
        logic [9:0]  cmd;
        logic [7:0]  miso;
        int          exp_low;
        logic [31:0] exp_mosi;
        int          exp_rdv;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        int          wait_cyc;
        int          low;
        int          hi;
        int          rdv;
        bit          rdv_first;
        bit          to;
        logic [31:0] mosi;
    } res_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one command and observe the frame up to the cycle where cmd_ready returns.
    task automatic run_frame(input logic [9:0] cmd, input logic [9:0] after_cmd,
                             input bit hold, input bit wiggle, output res_t r);
        int bud;
        r = '{default: 0};
        hif.cmd_data  = cmd;
        hif.cmd_valid = 1'b1;
        bud = 0;
        while (!hif.cmd_ready && bud < 100) begin
            @(negedge clk);
            r.wait_cyc++;
            bud++;
        end
        if (!hif.cmd_ready) r.to = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hif.cmd_valid = hold;
        hif.cmd_data  = after_cmd;
        bud = 0;
        while (SS_n == 1'b0 && bud < 64) begin
            r.low++;
            r.mosi = {r.mosi[30:0], MOSI};
            if (hif.rd_valid) r.rdv++;
            if (wiggle) begin
                hif.cmd_valid = r.low[0];
                hif.cmd_data  = ~cmd;
            end
            @(negedge clk);
            bud++;
        end
        if (bud >= 64) r.to = 1'b1;
        if (wiggle) hif.cmd_valid = 1'b0;
        r.rdv_first = hif.rd_valid;
        bud = 0;
        while (!hif.cmd_ready && bud < 64) begin
            if (hif.rd_valid) r.rdv++;
            if (SS_n) r.hi++;
            @(negedge clk);
            bud++;
        end
        if (bud >= 64) r.to = 1'b1;
    endtask

    vec_t tbl[6];
    res_t r, r2;
    int bad;

    initial begin
        tbl[0] = '{10'h0A5, 8'h00, 12,     32'h0A5,  0, 8'h00};
        tbl[1] = '{10'h300, 8'h5C, 12 + T, 32'h3C00, 1, 8'h5C};
        tbl[2] = '{10'h1FF, 8'hFF, 12,     32'h1FF,  0, 8'h5C};
        tbl[3] = '{10'h2C3, 8'h00, 12,     32'hEC3,  0, 8'h5C};
        tbl[4] = '{10'h3A7, 8'hA3, 12 + T, 32'h3C00, 1, 8'hA3};
        tbl[5] = '{10'h155, 8'h00, 12,     32'h155,  0, 8'hA3};

        rst = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_data  = 10'h000;
        miso_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_rd_valid", hif.rd_valid, 0);
        chk("rst_rd_data", hif.rd_data, 0);
        chk("rst_cmd_ready", hif.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", hif.cmd_ready, 1);
        chk("idle_ss_n", SS_n, 1);
        chk("idle_mosi", MOSI, 0);

        for (int i = 0; i < 6; i++) begin
            miso_byte = tbl[i].miso;
            run_frame(tbl[i].cmd, tbl[i].cmd, 1'b0, 1'b0, r);
            chk($sformatf("v%0d_timeout", i), r.to, 0);
            chk($sformatf("v%0d_low", i), r.low, tbl[i].exp_low);
            chk($sformatf("v%0d_mosi", i), r.mosi, tbl[i].exp_mosi);
            chk($sformatf("v%0d_rdv_cnt", i), r.rdv, tbl[i].exp_rdv);
            chk($sformatf("v%0d_rdv_first", i), r.rdv_first, tbl[i].exp_rdv);
            chk($sformatf("v%0d_gap", i), r.hi, GAP);
            chk($sformatf("v%0d_rd_data", i), hif.rd_data, tbl[i].exp_rd);
        end

        // Back-to-back with cmd_valid held high across both handshakes
        run_frame(10'h012, 10'h1FF, 1'b1, 1'b0, r);
        run_frame(10'h1FF, 10'h1FF, 1'b0, 1'b0, r2);
        chk("b2b_to", r.to | r2.to, 0);
        chk("b2b_low1", r.low, 12);
        chk("b2b_mosi1", r.mosi, 32'h012);
        chk("b2b_low2", r2.low, 12);
        chk("b2b_mosi2", r2.mosi, 32'h1FF);
        chk("b2b_ss_high", r.hi + 1 + r2.wait_cyc, GAP + 1);

        // cmd_valid/cmd_data wiggling while busy
        run_frame(10'h1C6, 10'h1C6, 1'b0, 1'b1, r);
        chk("wig_low", r.low, 12);
        chk("wig_mosi", r.mosi, 32'h1C6);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!SS_n) bad++;
        end
        chk("wig_no_extra_frame", bad, 0);

        // Reset in the middle of the READ phase of a read-data frame
        miso_byte = 8'h5C;
        hif.cmd_data  = 10'h300;
        hif.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        repeat (4 + T + 3) @(negedge clk);
        chk("mid_in_frame", SS_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ss_n", SS_n, 1);
        chk("mid_rst_rd_data", hif.rd_data, 0);
        chk("mid_rst_rd_valid", hif.rd_valid, 0);
        chk("mid_rst_mosi", MOSI, 0);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (hif.rd_valid || !SS_n) bad++;
        end
        chk("mid_rst_quiet", bad, 0);
        chk("mid_rst_ready", hif.cmd_ready, 1);
        run_frame(10'h2C3, 10'h2C3, 1'b0, 1'b0, r);
        chk("post_rst_to", r.to, 0);
        chk("post_rst_low", r.low, 12);
        chk("post_rst_mosi", r.mosi, 32'hEC3);
        chk("post_rst_rdv", r.rdv, 0);
        chk("post_rst_rd_data", hif.rd_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
